gate_resp_checker: RTL
======================

// Module: gate_resp_checker
// PURPOSE
//  Synthesizable response checker for the 2-input basic-gate benches: it is the receive end that a stimulus sweep feeds.
//  Each beat carries an input pair (A,B) and the DUT output Y. The block compares Y with the golden value
//  for the configured gate and tracks errors, vector count and input-combination coverage.
//  At session end it reports a single pass/fail verdict. It sits beside any gate DUT in a self-checking bench or on-board test.
// PARAMETERS
//  GATE_OP  1  golden function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; any other value is illegal.
//  CNT_W    8  width of the vector and error counters.
// PORTS
//  clk            in   1      single clock; all logic on the rising edge
//  rst            in   1      synchronous, active-high reset
//  start          in   1      opens a session; honoured only in IDLE or DONE
//  in_valid       in   1      beat present on in_a/in_b/in_y/in_last
//  in_ready       out  1      checker accepts a beat this cycle
//  in_a, in_b     in   1      DUT inputs applied on this beat
//  in_y           in   1      DUT output observed on this beat
//  in_last        in   1      final beat of the session
//  busy           out  1      session in progress (state RUN)
//  done           out  1      verdict valid (state DONE)
//  pass           out  1      verdict: err_cnt==0 and cov==4'b1111; valid only while done=1
//  err_cnt        out  CNT_W  number of mismatches, saturating
//  vec_cnt        out  CNT_W  number of accepted beats, saturating
//  cov            out  4      cov[{a,b}] set once combination {a,b} has been accepted
//  first_err_vec  out  2      {a,b} of the first mismatch; 2'b00 if there has been none
// BEHAVIOUR
//  Reset: state=IDLE. in_ready, busy, done, pass = 0. err_cnt, vec_cnt, cov, first_err_vec = 0. rst overrides every other input.
//  FSM IDLE -> RUN when start=1. In the same edge, clear err_cnt, vec_cnt, cov and first_err_vec.
//  FSM RUN: in_ready=1 and busy=1. A beat is accepted when in_valid && in_ready.
//   On an accepted beat:
//    - vec_cnt += 1, holding at 2^CNT_W-1.
//    - cov[{in_a,in_b}] <= 1.
//    - If in_y != golden(in_a,in_b): err_cnt += 1, holding at the maximum value.
//      On the first mismatch only, first_err_vec <= {in_a,in_b}.
//   An accepted beat with in_last=1 moves RUN -> DONE after applying its updates.
//   start is ignored while in RUN.
//  FSM DONE: done=1, in_ready=0. pass = (err_cnt==0) && (cov==4'hF). All results hold.
//   start=1 -> RUN with counters cleared (re-arm). in_valid is ignored.
//  Latency: the counters, cov and verdict reflect an accepted beat one cycle after its acceptance edge.
//   done asserts in the cycle after the in_last beat is accepted.
//  The handshake has no backpressure beyond state: in_ready depends only on state, never on in_valid.
//  Boundaries:
//   - A session of 0 beats cannot occur; a session ends only on an in_last beat.
//   - Repeated combinations count in vec_cnt; cov stays set.
//   - Saturation never wraps.
//   - rst in RUN or DONE aborts to IDLE with everything cleared.
// CONFIGURATION
//  GATE_CHK_STOP_ON_ERR_EN defined: the first mismatching beat also forces RUN -> DONE, as if in_last were set.
//   In that case err_cnt=1 and pass=0.
//  GATE_CHK_STOP_ON_ERR_EN undefined: mismatches are only counted, and the session runs until in_last.
// STRUCTURE
//  Package gate_chk_pkg holds:
//   - GATE_AND..GATE_XNOR opcode constants (0..5)
//   - FSM state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2
//  Sub-module gate_ref_model: combinational golden function, parameter GATE_OP, inputs a, b, output y_exp.
//  gate_resp_checker instantiates gate_ref_model once.
// TESTING
//  1 GATE_OP=1: start, then beats (0,0,0) (0,1,1) (1,0,1) (1,1,1, last)
//    -> done=1, pass=1, vec_cnt=4, err_cnt=0, cov=4'hF.
//  2 GATE_OP=1: same sweep with in_y=0 on the (1,0) beat
//    -> err_cnt=1, first_err_vec=2'b10, pass=0. With GATE_CHK_STOP_ON_ERR_EN, done asserts after that beat and vec_cnt=3.
//  3 Three correct beats (0,0) (0,1) (1,1, last)
//    -> cov=4'b1011, err_cnt=0, pass=0.
//  4 CNT_W=2: six correct beats -> vec_cnt holds at 3; later send all-wrong beats -> err_cnt holds at 3.
//  5 Pulse start mid-RUN -> counters are not cleared.
//    Assert rst mid-RUN -> next cycle IDLE with all outputs 0.
//    Assert start in DONE -> RUN with counters cleared.
//  6 in_valid=1 in IDLE and DONE -> in_ready=0 and no counter changes.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: opcodes for the golden gate function and the checker FSM state encoding.
`default_nettype none

package gate_chk_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XNOR = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden output of the configured 2-input gate.
`default_nettype none

module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int GATE_OP = GATE_OR
) (
  input  logic a,
  input  logic b,
  output logic y_exp
);

  // Illegal opcodes produce a constant 0.
  always_comb begin
    y_exp = 1'b0;
    case (GATE_OP)
      GATE_AND:  y_exp = a & b;
      GATE_OR:   y_exp = a | b;
      GATE_XOR:  y_exp = a ^ b;
      GATE_NAND: y_exp = ~(a & b);
      GATE_NOR:  y_exp = ~(a | b);
      GATE_XNOR: y_exp = ~(a ^ b);
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: compares gate-DUT beats with the golden function, tracks errors/coverage, gives a verdict.
// Option macro GATE_CHK_STOP_ON_ERR_EN: the first mismatching beat also ends the session.
`default_nettype none

module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int GATE_OP = GATE_OR,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_a_i,
  input  logic             in_b_i,
  input  logic             in_y_i,
  input  logic             in_last_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [3:0]       cov_o,
  output logic [1:0]       first_err_vec_o
);

`ifdef GATE_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic             ready_q, busy_q, done_q, pass_q;
  logic [CNT_W-1:0] err_q, err_d, vec_q, vec_d;
  logic [3:0]       cov_q, cov_d;
  logic [1:0]       fe_q, fe_d;
  logic             y_exp, accept, mism, end_run;

  gate_ref_model #(.GATE_OP(GATE_OP)) u_ref (
    .a     (in_a_i),
    .b     (in_b_i),
    .y_exp (y_exp)
  );

  assign accept  = in_valid_i && ready_q;
  assign mism    = in_y_i != y_exp;
  assign end_run = accept && (in_last_i || (STOP_ON_ERR && mism));

  // Post-beat result values; the verdict is taken from these on the closing beat.
  always_comb begin
    vec_d = vec_q;
    err_d = err_q;
    cov_d = cov_q;
    fe_d  = fe_q;
    if (accept) begin
      if (vec_q != CNT_MAX) vec_d = vec_q + CNT_ONE;
      cov_d[{in_a_i, in_b_i}] = 1'b1;
      if (mism) begin
        if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
        if (err_q == '0) fe_d = {in_a_i, in_b_i};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      vec_q   <= '0;
      cov_q   <= '0;
      fe_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            vec_q   <= '0;
            cov_q   <= '0;
            fe_q    <= '0;
          end
        end
        RUN: begin
          err_q <= err_d;
          vec_q <= vec_d;
          cov_q <= cov_d;
          fe_q  <= fe_d;
          if (end_run) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0) && (cov_d == 4'hF);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o      = ready_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_q;
  assign vec_cnt_o       = vec_q;
  assign cov_o           = cov_q;
  assign first_err_vec_o = fe_q;

endmodule

`default_nettype wire
